// File: rtl/read_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : read_buffer
//  Description : Unpacks one FULL_WIDTH read beat into WIDTH-bit elements and
//                pushes the element range [base, bounds) into a first-word-
//                fall-through FIFO, one element per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_buffer #(
   parameter int FULL_WIDTH = 512,
   parameter int WIDTH      = 64,
   parameter int LOG_DEPTH  = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [FULL_WIDTH-1:0] in_data,
   input  logic [7:0]            base,
   input  logic [7:0]            bounds,
   output logic                  in_ready,
   input  logic                  rdreq,
   output logic [WIDTH-1:0]      q,
   output logic                  empty,
   output logic                  full,
   output logic [LOG_DEPTH:0]    count
);

   localparam int ELEMS = FULL_WIDTH / WIDTH;
   localparam int SEL_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam int DEPTH = 1 << LOG_DEPTH;

   // Element indices are kept 9 bits wide so that ELEMS = 256 is representable.
   localparam logic [8:0]           C_ELEMS   = 9'(ELEMS);
   localparam logic [8:0]           C_IDX_ONE = 9'd1;
   localparam logic [LOG_DEPTH:0]   C_DEPTH   = (LOG_DEPTH + 1)'(DEPTH);
   localparam logic [LOG_DEPTH:0]   C_CNT_ONE = (LOG_DEPTH + 1)'(1);
   localparam logic [LOG_DEPTH-1:0] C_PTR_ONE = LOG_DEPTH'(1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_UNPACK = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [FULL_WIDTH-1:0] r_data;
   logic [8:0]            r_idx;
   logic [8:0]            r_lim;
   logic [8:0]            w_lim;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic [WIDTH-1:0]      w_elems [ELEMS];
   logic [WIDTH-1:0]      w_elem;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [LOG_DEPTH-1:0]  r_wr_ptr;
   logic [LOG_DEPTH-1:0]  r_rd_ptr;
   logic [LOG_DEPTH:0]    r_count;

   // Upper emit bound is clipped to the number of elements in a beat.
   assign w_lim = ({1'b0, bounds} < C_ELEMS) ? {1'b0, bounds} : C_ELEMS;

   // Slice the held beat into its elements.
   generate
      for (genvar gi = 0; gi < ELEMS; gi++) begin : g_elems
         assign w_elems[gi] = r_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   assign w_elem = w_elems[r_idx[SEL_W-1:0]];

   // FIFO status follows the registered occupancy, so writes are gated by it.
   assign full    = (r_count == C_DEPTH);
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign w_rd_en = rdreq & ~empty;
   assign q       = empty ? '0 : r_mem[r_rd_ptr];

   // Unpacker state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Unpacker next-state and handshake/write-enable decode.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_wr_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            // An empty range is consumed and dropped without leaving IDLE.
            if (in_valid && ({1'b0, base} < w_lim)) w_state_nxt = ST_UNPACK;
         end
         ST_UNPACK: begin
            if (!full) begin
               w_wr_en = 1'b1;
               if (r_idx == (r_lim - C_IDX_ONE)) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Beat capture on accept, then element index advance on each FIFO write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= '0;
         r_idx  <= '0;
         r_lim  <= '0;
      end else if ((r_state == ST_IDLE) && in_valid) begin
         r_data <= in_data;
         r_idx  <= {1'b0, base};
         r_lim  <= w_lim;
      end else if (w_wr_en) begin
         r_idx  <= r_idx + C_IDX_ONE;
      end
   end

   // FIFO storage; contents need no reset since q is masked while empty.
   always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= w_elem;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_read_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_buffer
//  Description : Directed self-checking bench for read_buffer (64-bit and
//                128-bit element configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_buffer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;

   // 64-bit element instance
   logic         in_valid = 1'b0;
   logic [511:0] in_data = '0;
   logic [7:0]   base = '0;
   logic [7:0]   bounds = '0;
   logic         in_ready;
   logic         rdreq = 1'b0;
   logic [63:0]  q;
   logic         empty;
   logic         full;
   logic [4:0]   count;

   // 128-bit element instance
   logic         in_valid_w = 1'b0;
   logic [511:0] in_data_w = '0;
   logic [7:0]   base_w = '0;
   logic [7:0]   bounds_w = '0;
   logic         in_ready_w;
   logic         rdreq_w = 1'b0;
   logic [127:0] q_w;
   logic         empty_w;
   logic         full_w;
   logic [4:0]   count_w;

   int n_checks = 0;
   int n_fail   = 0;

   read_buffer #(.FULL_WIDTH(512), .WIDTH(64), .LOG_DEPTH(4)) u_dut (
      .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .base(base), .bounds(bounds), .in_ready(in_ready), .rdreq(rdreq),
      .q(q), .empty(empty), .full(full), .count(count)
   );

   read_buffer #(.FULL_WIDTH(512), .WIDTH(128), .LOG_DEPTH(4)) u_dut_w (
      .clock(clk), .reset_n(rst_n), .in_valid(in_valid_w), .in_data(in_data_w),
      .base(base_w), .bounds(bounds_w), .in_ready(in_ready_w), .rdreq(rdreq_w),
      .q(q_w), .empty(empty_w), .full(full_w), .count(count_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mk64(input int start);
      logic [511:0] d = '0;
      for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(start + i);
      return d;
   endfunction

   task automatic send64(input logic [511:0] d, input logic [7:0] b, input logic [7:0] bnd);
      int n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
      if (!in_ready) check("ready_timeout", {127'b0, in_ready}, 128'd1);
      in_data  = d;
      base     = b;
      bounds   = bnd;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for a head element, checks it, and lets rdreq pop it.
   task automatic expect64(input string tag, input logic [63:0] exp);
      int n = 0;
      while (empty && n < 50) begin step(); n++; end
      check(tag, {64'b0, q}, {64'b0, exp});
      step();
   endtask

   task automatic expect128(input string tag, input logic [127:0] exp);
      int n = 0;
      while (empty_w && n < 50) begin step(); n++; end
      check(tag, q_w, exp);
      step();
   endtask

   initial begin
      logic [511:0] dw;

      // Reset state
      step(); step();
      check("rst_ready", {127'b0, in_ready}, 128'd1);
      check("rst_empty", {127'b0, empty},    128'd1);
      check("rst_full",  {127'b0, full},     128'd0);
      check("rst_count", {123'b0, count},    128'd0);
      check("rst_q",     {64'b0, q},         128'd0);
      rst_n = 1'b1;
      step();

      // Full beat, elements 1..8, streamed out one per cycle
      rdreq = 1'b1;
      send64(mk64(1), 8'd0, 8'd8);
      for (int i = 0; i < 8; i++) expect64("t1_q", 64'(1 + i));
      step();
      check("t1_empty", {127'b0, empty}, 128'd1);

      // Sub-range, clipped bounds, empty range
      send64(mk64(16'hA0), 8'd3, 8'd6);
      expect64("t2_q3", 64'hA3);
      expect64("t2_q4", 64'hA4);
      expect64("t2_q5", 64'hA5);
      step(); step();
      check("t2_range_empty", {127'b0, empty}, 128'd1);
      send64(mk64(16'hA0), 8'd6, 8'd12);
      expect64("t2_clip6", 64'hA6);
      expect64("t2_clip7", 64'hA7);
      step(); step();
      check("t2_clip_empty", {127'b0, empty}, 128'd1);
      send64(mk64(16'hA0), 8'd5, 8'd5);
      check("t2_null_ready", {127'b0, in_ready}, 128'd1);
      step(); step(); step();
      check("t2_null_empty", {127'b0, empty}, 128'd1);

      // Fill to full with three beats, third stalls, then drain in order
      rdreq = 1'b0;
      send64(mk64(100), 8'd0, 8'd8);
      send64(mk64(108), 8'd0, 8'd8);
      send64(mk64(116), 8'd0, 8'd8);
      step(); step(); step();
      check("t3_full",    {127'b0, full},     128'd1);
      check("t3_count",   {123'b0, count},    128'd16);
      check("t3_stall",   {127'b0, in_ready}, 128'd0);
      check("t3_head",    {64'b0, q},         128'd100);
      rdreq = 1'b1;
      for (int i = 0; i < 24; i++) expect64("t3_drain", 64'(100 + i));
      step();
      check("t3_empty", {127'b0, empty}, 128'd1);

      // Pop while empty is ignored
      step(); step(); step();
      check("t5_underflow_count", {123'b0, count}, 128'd0);
      check("t5_underflow_empty", {127'b0, empty}, 128'd1);

      // in_valid held during UNPACK must not start a second beat
      rdreq = 1'b0;
      send64(mk64(200), 8'd0, 8'd8);
      in_data  = mk64(300);
      in_valid = 1'b1;
      check("t5_busy_ready", {127'b0, in_ready}, 128'd0);
      step(); step(); step(); step();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("t5_busy_count", {123'b0, count}, 128'd8);
      rdreq = 1'b1;
      for (int i = 0; i < 8; i++) expect64("t5_busy_q", 64'(200 + i));
      step();
      check("t5_busy_empty", {127'b0, empty}, 128'd1);

      // 128-bit elements: four pairs, order preserved
      for (int i = 0; i < 4; i++) dw[i*128 +: 128] = {64'(16'h1000 + i), 64'(16'h2000 + i)};
      rdreq_w    = 1'b1;
      in_data_w  = dw;
      base_w     = 8'd0;
      bounds_w   = 8'd4;
      check("t4_ready", {127'b0, in_ready_w}, 128'd1);
      in_valid_w = 1'b1;
      step();
      in_valid_w = 1'b0;
      for (int i = 0; i < 4; i++)
         expect128("t4_pair", {64'(16'h1000 + i), 64'(16'h2000 + i)});
      step();
      check("t4_empty", {127'b0, empty_w}, 128'd1);

      // Asynchronous reset mid-UNPACK with five elements buffered
      rdreq = 1'b0;
      send64(mk64(400), 8'd0, 8'd8);
      for (int i = 0; i < 5; i++) step();
      check("t6_pre_count", {123'b0, count}, 128'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_empty", {127'b0, empty},    128'd1);
      check("t6_count", {123'b0, count},    128'd0);
      check("t6_ready", {127'b0, in_ready}, 128'd1);
      check("t6_q",     {64'b0, q},         128'd0);
      #1;
      rst_n = 1'b1;
      step(); step();
      check("t6_post_empty", {127'b0, empty}, 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
